mmio_peripheral_responder: RTL and testbench
============================================

Name: mmio_peripheral_responder

Overview:
- Memory-mapped peripheral responder on the processor's data/instruction memory bus (write_mem, funct3, write_address, write_data, read_address, read_data, mem_busy).
- Decodes the top 256-byte region 0xFFFFFF00-0xFFFFFFFF. Holds the LED/RGB PWM duty registers and free-running microsecond/millisecond timers.
- Drives active-low LED/RGB outputs and stretches bus accesses with programmable wait states via mem_busy.
- Sits beside the RAM block; the top level muxes read_data using read_hit.

Parameters:
CLK_FREQ_HZ, 12000000, system clock frequency; micro tick every CLK_FREQ_HZ/1000000 cycles (12 at default).
WAIT_STATES, 1, cycles mem_busy stays asserted after each new access (0..15).
PWM_DIV, 47, prescaler; 8-bit PWM counter advances every PWM_DIV+1 clocks.

Ports:
clk  in  1  system clock; all state changes on posedge.
rst_n  in  1  synchronous reset, active-low.
write_mem  in  1  store request, held high by initiator for the store cycle(s).
funct3  in  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
write_address  in  32  store byte address.
write_data  in  32  store data, right-aligned (lane 0 = bits 7:0).
read_address  in  32  load byte address.
read_data  out  32  registered, extended load data.
read_hit  out  1  registered; 1 when the last captured read_address is in the peripheral region.
mem_busy  out  1  initiator must hold its access while high.
led  out  1  active-low PWM output.
red  out  1  active-low PWM output.
green  out  1  active-low PWM output.
blue  out  1  active-low PWM output.

Behaviour:
- Reset (rst_n low at posedge):
  - read_data=0, read_hit=0, mem_busy=0.
  - State IDLE; all duty registers, timers, PWM counter and prescaler = 0.
  - Last-read-address register = 0, write_mem_d = 0.
  - led/red/green/blue=1 (off).
  - Reset mid-WAIT aborts the access: IDLE next cycle, no write committed.
- Region hit: address[31:8]==24'hFFFFFF.
- Register offsets (address[7:0]):
  - FC led duty, F8 red duty, F4 green duty, F0 blue duty: 8 bits each, read back zero-extended.
  - EC millis: read-only.
  - E8 micros: read-only.
  - All other offsets read 0; writes to them are ignored.
- Triggers:
  - read trigger = read_address != last-read-address register.
  - write trigger = write_mem & ~write_mem_d; a store commits exactly once per rising edge of write_mem.
- FSM IDLE/WAIT:
  - IDLE, trigger, WAIT_STATES>0: load wait counter with WAIT_STATES, go to WAIT.
  - mem_busy is combinational: (state==WAIT) | (trigger & WAIT_STATES!=0). It is therefore high on the trigger cycle.
  - WAIT: decrement counter; at 1, go to IDLE and capture read_data/read_hit.
  - WAIT_STATES=0: capture on the trigger cycle; mem_busy stays 0.
  - A new trigger during WAIT is ignored until IDLE. The initiator holds its addresses while busy.
- Write commit: on the trigger cycle, if write_address is a region hit and aligned:
  - sb: lane address[1:0]. Only lane 0 of a duty register stores (bits 7:0); other lanes are ignored.
  - sh: lanes 0-1.
  - sw: all lanes; duty keeps bits 7:0.
- Read capture uses register values from the start of the capture cycle; a same-cycle store is not visible.
- Load extraction:
  - Lane = address[1:0].
  - lb/lh sign-extend; lbu/lhu/lw zero-fill as applicable.
- Misalignment:
  - lh/lhu/sh with address[0]=1, or lw/sw with address[1:0]!=0: read returns 0, write ignored.
  - Unlisted funct3: read 0, write ignored.
- Non-hit read: read_data=0, read_hit=0.
- PWM:
  - Prescaler counts 0..PWM_DIV, then the 8-bit counter increments and wraps 255 to 0.
  - Output = ~(pwm_cnt < duty): duty 0 always 1 (off); duty 255 low 255/256 of the time.
  - Outputs are registered.
- Timers:
  - micros increments every CLK_FREQ_HZ/1000000 clocks.
  - millis increments on every 1000th micros tick.
  - Both wrap at 2^32 with no saturation.

Optional Feature:
MMIO_TIMER_EN
- Defined: micros/millis counters and their tick dividers are built; EC/E8 read as specified.
- Undefined: no timer logic is synthesised; EC/E8 read 0 and are treated as unused offsets.

Test Plan:
- Reset hold 3 cycles, release -> read_data=0, mem_busy=0, led/red/green/blue=1; WAIT_STATES=1: first read to 0xFFFFFFFC -> mem_busy high exactly 1 cycle, read_data=0.
- sw 0x000000FF to 0xFFFFFFF8, then lw 0xFFFFFFF8 -> read_data=0x000000FF, read_hit=1; red low for 255 of every 256 PWM steps.
- sb 0x80 to 0xFFFFFFFC, then lb -> 0xFFFFFF80; lbu -> 0x00000080; sb 0x11 to 0xFFFFFFFD -> led duty unchanged (0x80).
- lw 0xFFFFFFFA (misaligned) -> read_data=0; sw to 0xFFFFFFF6 -> green duty unchanged; lw 0x00000100 -> read_data=0, read_hit=0.
- With MMIO_TIMER_EN: run 12000 clocks after reset, lw 0xFFFFFFE8 -> 1000 (+/-1), lw 0xFFFFFFEC -> 1; without MMIO_TIMER_EN -> both 0.
- WAIT_STATES=3: hold write_mem high 5 cycles with sw 0x42 to 0xFFFFFFF0 -> mem_busy high 3 cycles, single commit, blue duty=0x42; assert rst_n low during WAIT -> mem_busy=0 next cycle, duty=0.

Source files
------------

// File: rtl/mmio_peripheral_responder.sv
// rtl/mmio_peripheral_responder.sv - MMIO responder for 0xFFFFFF00 region: PWM duty registers, timers, wait states
// Optional feature macro: MMIO_TIMER_EN builds the micros (E8) and millis (EC) timers.
module mmio_peripheral_responder #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int WAIT_STATES = 1,
    parameter int PWM_DIV     = 47
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        read_hit,
    output logic        mem_busy,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [3:0]  WS4       = 4'(WAIT_STATES);
    localparam bit          HAS_WAIT  = (WAIT_STATES != 0);
    localparam logic [15:0] PWM_LAST  = 16'(PWM_DIV);
    localparam int          US_DIV_I  = (CLK_FREQ_HZ / 1000000 > 0) ? (CLK_FREQ_HZ / 1000000) : 1;
    localparam logic [23:0] US_LAST   = 24'(US_DIV_I - 1);

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_read_data;
    logic        r_read_hit;
    logic [31:0] r_last_raddr;
    logic        r_write_mem_d;
    logic [7:0]  r_led_duty;
    logic [7:0]  r_red_duty;
    logic [7:0]  r_green_duty;
    logic [7:0]  r_blue_duty;
    logic [15:0] r_presc;
    logic [7:0]  r_pwm_cnt;
    logic        r_led;
    logic        r_red;
    logic        r_green;
    logic        r_blue;

`ifdef MMIO_TIMER_EN
    logic [23:0] r_us_div;
    logic [9:0]  r_ms_div;
    logic [31:0] r_micros;
    logic [31:0] r_millis;
`endif

    logic        w_read_trig;
    logic        w_write_trig;
    logic        w_trig;
    logic        w_idle_trig;
    logic        w_rd_hit;
    logic        w_wr_hit;
    logic        w_wr_ok;
    logic        w_commit;
    logic [31:0] w_word;
    logic [31:0] w_shifted;
    logic [31:0] w_load;
    logic        w_unused;

    // High data bits of stores never reach the 8-bit duty registers.
    assign w_unused = ^write_data[31:8] ^ US_LAST[0];

    assign w_read_trig  = (read_address != r_last_raddr);
    assign w_write_trig = write_mem & ~r_write_mem_d;
    assign w_trig       = rst_n & (w_read_trig | w_write_trig);
    assign w_idle_trig  = (r_state == S_IDLE) & w_trig;
    assign mem_busy     = rst_n & ((r_state == S_WAIT) | (w_trig & HAS_WAIT));

    assign w_rd_hit = (read_address[31:8] == 24'hFFFFFF);
    assign w_wr_hit = (write_address[31:8] == 24'hFFFFFF);

    // Store legality: only sb/sh/sw, naturally aligned.
    always_comb begin
        w_wr_ok = 1'b0;
        case (funct3)
            3'b000:  w_wr_ok = 1'b1;
            3'b001:  w_wr_ok = ~write_address[0];
            3'b010:  w_wr_ok = (write_address[1:0] == 2'b00);
            default: w_wr_ok = 1'b0;
        endcase
    end

    // Duty registers live in lane 0 only; stores touching other lanes leave them alone.
    assign w_commit = w_idle_trig & w_write_trig & w_wr_hit & w_wr_ok
                    & (write_address[1:0] == 2'b00);

    // Word view of the register addressed by read_address.
    always_comb begin
        w_word = 32'h0;
        case (read_address[7:2])
            6'h3F:   w_word = {24'h0, r_led_duty};
            6'h3E:   w_word = {24'h0, r_red_duty};
            6'h3D:   w_word = {24'h0, r_green_duty};
            6'h3C:   w_word = {24'h0, r_blue_duty};
`ifdef MMIO_TIMER_EN
            6'h3B:   w_word = r_millis;
            6'h3A:   w_word = r_micros;
`endif
            default: w_word = 32'h0;
        endcase
    end

    assign w_shifted = w_word >> {read_address[1:0], 3'b000};

    // Lane extraction with sign/zero extension; misaligned or unknown sizes read 0.
    always_comb begin
        w_load = 32'h0;
        if (w_rd_hit) begin
            case (funct3)
                3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
                3'b001:  w_load = read_address[0] ? 32'h0 : {{16{w_shifted[15]}}, w_shifted[15:0]};
                3'b010:  w_load = (read_address[1:0] == 2'b00) ? w_word : 32'h0;
                3'b100:  w_load = {24'h0, w_shifted[7:0]};
                3'b101:  w_load = read_address[0] ? 32'h0 : {16'h0, w_shifted[15:0]};
                default: w_load = 32'h0;
            endcase
        end
    end

    // Access FSM: stretch each new access by WAIT_STATES cycles, then capture load data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= 4'h0;
            r_read_data   <= 32'h0;
            r_read_hit    <= 1'b0;
            r_last_raddr  <= 32'h0;
            r_write_mem_d <= 1'b0;
        end else begin
            r_write_mem_d <= write_mem;
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        if (HAS_WAIT) begin
                            r_wait_cnt <= WS4;
                            r_state    <= S_WAIT;
                        end else begin
                            r_read_data  <= w_load;
                            r_read_hit   <= w_rd_hit;
                            r_last_raddr <= read_address;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 4'd1) begin
                        r_state      <= S_IDLE;
                        r_read_data  <= w_load;
                        r_read_hit   <= w_rd_hit;
                        r_last_raddr <= read_address;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Duty register writes, committed once on the store's trigger cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led_duty   <= 8'h0;
            r_red_duty   <= 8'h0;
            r_green_duty <= 8'h0;
            r_blue_duty  <= 8'h0;
        end else if (w_commit) begin
            case (write_address[7:2])
                6'h3F:   r_led_duty   <= write_data[7:0];
                6'h3E:   r_red_duty   <= write_data[7:0];
                6'h3D:   r_green_duty <= write_data[7:0];
                6'h3C:   r_blue_duty  <= write_data[7:0];
                default: ;
            endcase
        end
    end

    // PWM timebase: prescaler then free-running 8-bit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc   <= 16'h0;
            r_pwm_cnt <= 8'h0;
        end else if (r_presc == PWM_LAST) begin
            r_presc   <= 16'h0;
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // Registered active-low PWM outputs; duty 0 keeps the output off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led   <= 1'b1;
            r_red   <= 1'b1;
            r_green <= 1'b1;
            r_blue  <= 1'b1;
        end else begin
            r_led   <= ~(r_pwm_cnt < r_led_duty);
            r_red   <= ~(r_pwm_cnt < r_red_duty);
            r_green <= ~(r_pwm_cnt < r_green_duty);
            r_blue  <= ~(r_pwm_cnt < r_blue_duty);
        end
    end

`ifdef MMIO_TIMER_EN
    // Free-running microsecond and millisecond counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_us_div <= 24'h0;
            r_ms_div <= 10'h0;
            r_micros <= 32'h0;
            r_millis <= 32'h0;
        end else if (r_us_div == US_LAST) begin
            r_us_div <= 24'h0;
            r_micros <= r_micros + 32'd1;
            if (r_ms_div == 10'd999) begin
                r_ms_div <= 10'h0;
                r_millis <= r_millis + 32'd1;
            end else begin
                r_ms_div <= r_ms_div + 10'd1;
            end
        end else begin
            r_us_div <= r_us_div + 24'd1;
        end
    end
`endif

    assign read_data = r_read_data;
    assign read_hit  = r_read_hit;
    assign led       = r_led;
    assign red       = r_red;
    assign green     = r_green;
    assign blue      = r_blue;

endmodule

// File: tb/tb_mmio_peripheral_responder.sv
// tb/tb_mmio_peripheral_responder.sv - directed bench for mmio_peripheral_responder (WAIT_STATES 1 and 3)
module tb_mmio_peripheral_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] read_address;

    logic [31:0] rdata1, rdata3;
    logic        hit1, hit3, busy1, busy3;
    logic        led1, red1, green1, blue1;
    logic        led3, red3, green3, blue3;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_ra;

    always #5 clk = ~clk;

    mmio_peripheral_responder #(.CLK_FREQ_HZ(12000000), .WAIT_STATES(1), .PWM_DIV(47)) u_dut (
        .clk(clk), .rst_n(rst_n), .write_mem(write_mem), .funct3(funct3),
        .write_address(write_address), .write_data(write_data), .read_address(read_address),
        .read_data(rdata1), .read_hit(hit1), .mem_busy(busy1),
        .led(led1), .red(red1), .green(green1), .blue(blue1)
    );

    mmio_peripheral_responder #(.CLK_FREQ_HZ(12000000), .WAIT_STATES(3), .PWM_DIV(47)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .write_mem(write_mem), .funct3(funct3),
        .write_address(write_address), .write_data(write_data), .read_address(read_address),
        .read_data(rdata3), .read_hit(hit3), .mem_busy(busy3),
        .led(led3), .red(red3), .green(green3), .blue(blue3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; write_mem = 1'b0; read_address = 32'h0; last_ra = 32'h0;
        repeat (3) tick;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle1;
        int n;
        n = 0;
        while (busy1 && n < 32) begin tick; n++; end
        if (busy1) begin
            vectors++; miscompares++;
            $display("FAIL busy1_timeout got %b want 0", busy1);
        end
    endtask

    task automatic wait_idle3;
        int n;
        n = 0;
        while (busy3 && n < 32) begin tick; n++; end
        if (busy3) begin
            vectors++; miscompares++;
            $display("FAIL busy3_timeout got %b want 0", busy3);
        end
    endtask

    task automatic rd1(input logic [31:0] a, input logic [2:0] f3);
        if (a == last_ra) begin
            read_address = 32'h10; last_ra = 32'h10; #1; wait_idle1;
        end
        read_address = a; funct3 = f3; last_ra = a; #1;
        wait_idle1;
    endtask

    task automatic rd3(input logic [31:0] a, input logic [2:0] f3);
        if (a == last_ra) begin
            read_address = 32'h10; last_ra = 32'h10; #1; wait_idle3;
        end
        read_address = a; funct3 = f3; last_ra = a; #1;
        wait_idle3;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        write_address = a; write_data = d; funct3 = f3; write_mem = 1'b1; #1;
        wait_idle1;
        write_mem = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        funct3 = 3'b010; write_address = 32'h0; write_data = 32'h0;
        do_reset;
        tick;
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL reset_read_data got %h want 00000000", rdata1); end
        vectors++; if (hit1 !== 1'b0) begin miscompares++; $display("FAIL reset_read_hit got %b want 0", hit1); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_mem_busy got %b want 0", busy1); end
        vectors++; if ({led1, red1, green1, blue1} !== 4'b1111) begin miscompares++; $display("FAIL reset_pwm_outputs got %b want 1111", {led1, red1, green1, blue1}); end
    endtask

    task automatic test_first_read;
        int stretch;
        read_address = 32'hFFFFFFFC; funct3 = 3'b010; last_ra = 32'hFFFFFFFC; #1;
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL first_read_trigger_busy got %b want 1", busy1); end
        stretch = 0;
        for (int i = 0; i < 4; i++) begin tick; if (busy1) stretch++; end
        vectors++; if (stretch != 1) begin miscompares++; $display("FAIL first_read_wait_cycles got %0d want 1", stretch); end
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL first_read_data got %h want 00000000", rdata1); end
        vectors++; if (hit1 !== 1'b1) begin miscompares++; $display("FAIL first_read_hit got %b want 1", hit1); end
    endtask

    task automatic test_red_full;
        int red_low, led_low;
        wr1(32'hFFFFFFF8, 32'h000000FF, 3'b010);
        rd1(32'hFFFFFFF8, 3'b010);
        vectors++; if (rdata1 !== 32'h000000FF) begin miscompares++; $display("FAIL red_duty_readback got %h want 000000ff", rdata1); end
        vectors++; if (hit1 !== 1'b1) begin miscompares++; $display("FAIL red_duty_hit got %b want 1", hit1); end
        red_low = 0; led_low = 0;
        repeat (256 * 48) begin
            tick;
            if (red1 === 1'b0) red_low++;
            if (led1 === 1'b0) led_low++;
        end
        vectors++; if (red_low != 255 * 48) begin miscompares++; $display("FAIL red_low_cycles got %0d want %0d", red_low, 255 * 48); end
        vectors++; if (led_low != 0) begin miscompares++; $display("FAIL led_off_cycles got %0d want 0", led_low); end
    endtask

    task automatic test_byte_access;
        wr1(32'hFFFFFFFC, 32'h00000080, 3'b000);
        rd1(32'hFFFFFFFC, 3'b000);
        vectors++; if (rdata1 !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_led got %h want ffffff80", rdata1); end
        rd1(32'hFFFFFFFC, 3'b100);
        vectors++; if (rdata1 !== 32'h00000080) begin miscompares++; $display("FAIL lbu_led got %h want 00000080", rdata1); end
        rd1(32'hFFFFFFFC, 3'b001);
        vectors++; if (rdata1 !== 32'h00000080) begin miscompares++; $display("FAIL lh_led got %h want 00000080", rdata1); end
        wr1(32'hFFFFFFFD, 32'h00000011, 3'b000);
        rd1(32'hFFFFFFFC, 3'b010);
        vectors++; if (rdata1 !== 32'h00000080) begin miscompares++; $display("FAIL sb_lane1_ignored got %h want 00000080", rdata1); end
        rd1(32'hFFFFFFFD, 3'b100);
        vectors++; if (rdata1 !== 32'h00000000) begin miscompares++; $display("FAIL lbu_lane1 got %h want 00000000", rdata1); end
        rd1(32'hFFFFFFFC, 3'b011);
        vectors++; if (rdata1 !== 32'h00000000) begin miscompares++; $display("FAIL unlisted_funct3 got %h want 00000000", rdata1); end
    endtask

    task automatic test_misaligned;
        rd1(32'hFFFFFFFA, 3'b010);
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL lw_misaligned got %h want 00000000", rdata1); end
        vectors++; if (hit1 !== 1'b1) begin miscompares++; $display("FAIL lw_misaligned_hit got %b want 1", hit1); end
        wr1(32'hFFFFFFF6, 32'h00000055, 3'b010);
        rd1(32'hFFFFFFF4, 3'b010);
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL sw_misaligned_ignored got %h want 00000000", rdata1); end
        wr1(32'hFFFFFFF4, 32'h0000ABCD, 3'b001);
        rd1(32'hFFFFFFF4, 3'b001);
        vectors++; if (rdata1 !== 32'h000000CD) begin miscompares++; $display("FAIL sh_green_lh got %h want 000000cd", rdata1); end
        rd1(32'hFFFFFFF4, 3'b000);
        vectors++; if (rdata1 !== 32'hFFFFFFCD) begin miscompares++; $display("FAIL sh_green_lb got %h want ffffffcd", rdata1); end
        rd1(32'h00000100, 3'b010);
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL non_hit_data got %h want 00000000", rdata1); end
        vectors++; if (hit1 !== 1'b0) begin miscompares++; $display("FAIL non_hit_flag got %b want 0", hit1); end
    endtask

    task automatic test_timers;
        do_reset;
        repeat (12005) tick;
        rd1(32'hFFFFFFE8, 3'b010);
`ifdef MMIO_TIMER_EN
        vectors++; if ($isunknown(rdata1) || rdata1 < 32'd999 || rdata1 > 32'd1001) begin miscompares++; $display("FAIL micros got %0d want 1000+/-1", rdata1); end
`else
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL micros_disabled got %h want 00000000", rdata1); end
`endif
        rd1(32'hFFFFFFEC, 3'b010);
`ifdef MMIO_TIMER_EN
        vectors++; if (rdata1 !== 32'd1) begin miscompares++; $display("FAIL millis got %0d want 1", rdata1); end
`else
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL millis_disabled got %h want 00000000", rdata1); end
`endif
    endtask

    task automatic test_ws3_hold;
        int stretch;
        do_reset;
        tick;
        write_address = 32'hFFFFFFF0; write_data = 32'h00000042; funct3 = 3'b010; write_mem = 1'b1; #1;
        vectors++; if (busy3 !== 1'b1) begin miscompares++; $display("FAIL ws3_trigger_busy got %b want 1", busy3); end
        stretch = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            write_data = 32'h00000099;
            if (busy3) stretch++;
        end
        vectors++; if (stretch != 3) begin miscompares++; $display("FAIL ws3_wait_cycles got %0d want 3", stretch); end
        write_mem = 1'b0;
        tick;
        vectors++; if (busy3 !== 1'b0) begin miscompares++; $display("FAIL ws3_busy_after got %b want 0", busy3); end
        rd3(32'hFFFFFFF0, 3'b010);
        vectors++; if (rdata3 !== 32'h00000042) begin miscompares++; $display("FAIL ws3_single_commit got %h want 00000042", rdata3); end
        vectors++; if (hit3 !== 1'b1) begin miscompares++; $display("FAIL ws3_hit got %b want 1", hit3); end
    endtask

    task automatic test_reset_mid_wait;
        write_address = 32'hFFFFFFF0; write_data = 32'h00000077; funct3 = 3'b010; write_mem = 1'b1; #1;
        tick;
        vectors++; if (busy3 !== 1'b1) begin miscompares++; $display("FAIL mid_wait_busy got %b want 1", busy3); end
        rst_n = 1'b0; write_mem = 1'b0; read_address = 32'h0; last_ra = 32'h0;
        tick;
        vectors++; if (busy3 !== 1'b0) begin miscompares++; $display("FAIL mid_wait_reset_busy got %b want 0", busy3); end
        tick;
        rst_n = 1'b1;
        tick;
        vectors++; if (busy3 !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy got %b want 0", busy3); end
        rd3(32'hFFFFFFF0, 3'b010);
        vectors++; if (rdata3 !== 32'h0) begin miscompares++; $display("FAIL post_reset_blue_duty got %h want 00000000", rdata3); end
    endtask

    initial begin
        test_reset;
        test_first_read;
        test_red_full;
        test_byte_access;
        test_misaligned;
        test_timers;
        test_ws3_hold;
        test_reset_mid_wait;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
